poly_host_bridge: RTL

POLY_HOST_BRIDGE -- requirements
Module: poly_host_bridge

---
 rtl/poly_host_bridge.sv | 81 ++++++++
 1 files changed

// File: rtl/poly_host_bridge.sv
// poly_host_bridge: host stream <-> dual-port operand BRAM bridge for the POLY multiplier
//   clock_i, reset_n_i          : clock, asynchronous active-low reset
//   s_data_i/s_valid_i/s_ready_o: operand words in (A, B, M, M'_0 written to BRAM 0..3NS+N-1)
//   m_data_o/m_valid_o/m_ready_i: result words out (read from BRAM 3NS+N..4NS+N-1)
//   BRAM_*                      : host-side BRAM port, 1-cycle read latency
//   load_start_o, store_done_i  : handshake with the POLY memory controller
//   busy_o, done_o              : transaction in progress / completion pulse
module poly_host_bridge #(
    parameter int WORD_WIDTH = 17,
    parameter int N = 5,
    parameter int S = 4,
    localparam int ADDR_LEN = $clog2(4*N*S+N)+1
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic [WORD_WIDTH-1:0] s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [WORD_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  BRAM_we_o,
    output logic [ADDR_LEN-1:0]   BRAM_addr_o,
    output logic [WORD_WIDTH-1:0] BRAM_din_o,
    input  logic [WORD_WIDTH-1:0] BRAM_dout_i,
    output logic                  load_start_o,
    input  logic                  store_done_i,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int OP_WORDS = 3*N*S+N;
    localparam logic [ADDR_LEN-1:0] OP_LAST  = ADDR_LEN'(OP_WORDS-1);
    localparam logic [ADDR_LEN-1:0] RES_BASE = ADDR_LEN'(OP_WORDS);
    localparam logic [ADDR_LEN-1:0] RES_LAST = ADDR_LEN'(N*S-1);
    typedef enum logic [2:0] {
        IDLE = 3'd0, WRITE_OPS = 3'd1, START = 3'd2, WAIT_RES = 3'd3,
        RD_ADDR = 3'd4, RD_DATA = 3'd5, SEND = 3'd6, DONE = 3'd7
    } state_t;
    state_t state, next;
    logic [ADDR_LEN-1:0] wr_cnt, rd_cnt;
    logic hs;
    assign hs = s_valid_i & s_ready_o;
    always_ff @(posedge clock_i or negedge reset_n_i)
        if (!reset_n_i) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            IDLE, WRITE_OPS: if (hs) next = (wr_cnt == OP_LAST) ? START : WRITE_OPS;
            START:           next = WAIT_RES;
            WAIT_RES:        if (store_done_i) next = RD_ADDR;
            RD_ADDR:         next = RD_DATA;
            RD_DATA:         next = SEND;
            SEND:            if (m_ready_i) next = (rd_cnt == RES_LAST) ? DONE : RD_ADDR;
            default:         next = IDLE;
        endcase
    end
    // s_ready_o is gated by reset so no write can be issued while reset is held
    always_comb begin
        s_ready_o    = reset_n_i & (state == IDLE || state == WRITE_OPS);
        BRAM_we_o    = hs;
        BRAM_din_o   = s_data_i;
        BRAM_addr_o  = (state == RD_ADDR) ? RES_BASE + rd_cnt : wr_cnt;
        load_start_o = state == START;
        m_valid_o    = state == SEND;
        done_o       = state == DONE;
        busy_o       = state != IDLE;
    end
    // rd_cnt saturates on the last word; DONE returns it to zero
    always_ff @(posedge clock_i or negedge reset_n_i)
        if (!reset_n_i) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            m_data_o <= '0;
        end else begin
            if (hs) wr_cnt <= (wr_cnt == OP_LAST) ? '0 : wr_cnt + ADDR_LEN'(1);
            if (state == DONE) rd_cnt <= '0;
            else if (state == SEND && m_ready_i && rd_cnt != RES_LAST) rd_cnt <= rd_cnt + ADDR_LEN'(1);
            if (state == RD_DATA) m_data_o <= BRAM_dout_i;
        end
endmodule
